// File: rtl/seq_det_sched.sv
// Four-lane zero-run detector sharing one Mealy detector through a round-robin arbiter.
// Optional per-lane saturating match counters are built when SEQ_MATCH_CNT_EN is defined.
module seq_det_sched #(
  parameter int RUN_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [3:0] req,
  input  logic [3:0] bit_in,
  output logic [3:0] gnt,
  output logic       match_valid,
  output logic [1:0] match_lane,
  input  logic [1:0] rd_lane,
  output logic [7:0] rd_cnt
);

  localparam logic [3:0] RUN_SAT = 4'(RUN_LEN);
  localparam logic [3:0] RUN_THR = 4'(RUN_LEN - 1);

  logic [1:0] ptr;
  logic [3:0] run [4];

  logic       grant_any;
  logic [1:0] grant_lane;
  logic [1:0] scan_idx;
  logic       grant_bit;
  logic [3:0] cur_run;
  logic       detect;
  logic [3:0] next_run;

  // Scan from ptr upward with 2-bit wrap; reset and clear suppress any grant.
  always_comb begin
    grant_any  = 1'b0;
    grant_lane = ptr;
    scan_idx   = ptr;
    gnt        = 4'b0000;
    if (!rst && !clr) begin
      for (int i = 0; i < 4; i++) begin
        scan_idx = ptr + 2'(i);
        if (!grant_any && req[scan_idx]) begin
          grant_any  = 1'b1;
          grant_lane = scan_idx;
        end
      end
    end
    if (grant_any) gnt = 4'b0001 << grant_lane;
  end

  // Shared detector operates on the granted lane's saved context.
  always_comb begin
    grant_bit = bit_in[grant_lane];
    cur_run   = run[grant_lane];
    detect    = grant_any && !grant_bit && (cur_run >= RUN_THR);
    if (grant_bit)   next_run = 4'd0;
    else if (detect) next_run = RUN_SAT;
    else             next_run = cur_run + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= 2'd0;
      match_valid <= 1'b0;
      match_lane  <= 2'd0;
    end else if (clr) begin
      ptr         <= 2'd0;
      match_valid <= 1'b0;
    end else begin
      match_valid <= detect;
      if (grant_any) ptr <= grant_lane + 2'd1;
      if (detect) match_lane <= grant_lane;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          run[gi] <= 4'd0;
        else if (clr)
          run[gi] <= 4'd0;
        else if (grant_any && grant_lane == 2'(gi))
          run[gi] <= next_run;
      end
    end
  endgenerate

`ifdef SEQ_MATCH_CNT_EN
  logic [7:0] cnt [4];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt[gi] <= 8'd0;
        else if (clr)
          cnt[gi] <= 8'd0;
        else if (detect && grant_lane == 2'(gi) && cnt[gi] != 8'hff)
          cnt[gi] <= cnt[gi] + 8'd1;
      end
    end
  endgenerate

  assign rd_cnt = cnt[rd_lane];
`else
  assign rd_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed and randomized checks of seq_det_sched against a trailing-zero-count model.
module tb_seq_det_sched;
  localparam int RUN_LEN = 3;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [3:0] req, bit_in, gnt;
  logic       match_valid;
  logic [1:0] match_lane, rd_lane;
  logic [7:0] rd_cnt;

  seq_det_sched #(.RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .bit_in(bit_in), .gnt(gnt),
    .match_valid(match_valid), .match_lane(match_lane), .rd_lane(rd_lane), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: a lane matches when its trailing run of consumed zeros is at least RUN_LEN long.
  int   m_zeros [4];
  int   m_cnt   [4];
  int   m_ptr;
  logic m_mv;
  logic [1:0] m_ml;
  logic [3:0] last_gnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic c);
    if (c) return 4'b0000;
    for (int i = 0; i < 4; i++) begin
      int l;
      l = (m_ptr + i) % 4;
      if (r[l]) return 4'b0001 << l;
    end
    return 4'b0000;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [1:0] lane);
`ifdef SEQ_MATCH_CNT_EN
    return (m_cnt[lane] > 255) ? 8'd255 : 8'(m_cnt[lane]);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_zeros[i] = 0;
      m_cnt[i]   = 0;
    end
    m_ptr = 0;
    m_mv  = 1'b0;
    m_ml  = 2'd0;
  endtask

  // Called at posedge+1: drive inputs, check gnt mid-cycle, then check registered outputs.
  task automatic step(input logic [3:0] r, input logic [3:0] b, input logic c, input logic [1:0] rl);
    logic [3:0] eg;
    int k;
    req = r; bit_in = b; clr = c; rd_lane = rl;
    @(negedge clk);
    eg = model_gnt(r, c);
    chk("gnt", {4'd0, gnt}, {4'd0, eg});
    @(posedge clk);
    last_gnt = eg;
    m_mv = 1'b0;
    if (c) begin
      for (int i = 0; i < 4; i++) begin
        m_zeros[i] = 0;
        m_cnt[i]   = 0;
      end
      m_ptr = 0;
    end else if (eg != 4'b0000) begin
      k = $clog2(eg);
      if (b[k]) m_zeros[k] = 0;
      else begin
        m_zeros[k]++;
        if (m_zeros[k] >= RUN_LEN) begin
          m_mv = 1'b1;
          m_ml = 2'(k);
          m_cnt[k]++;
        end
      end
      m_ptr = (k + 1) % 4;
    end
    #1;
    chk("match_valid", {7'd0, match_valid}, {7'd0, m_mv});
    if (m_mv) chk("match_lane", {6'd0, match_lane}, {6'd0, m_ml});
    chk("rd_cnt", rd_cnt, exp_rd(rl));
  endtask

  task automatic pulse_reset();
    req = 4'b1111; bit_in = 4'b0000; clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt", {4'd0, gnt}, 8'd0);
    chk("rst_mv", {7'd0, match_valid}, 8'd0);
    chk("rst_ml", {6'd0, match_lane}, 8'd0);
    chk("rst_cnt", rd_cnt, 8'd0);
    @(posedge clk); #1;
    chk("rst_hold_mv", {7'd0, match_valid}, 8'd0);
    req = 4'b0000;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic       pend  [4];
  logic       pbit  [4];
  logic [3:0] rv, bv;

  initial begin
    rst = 1'b1; clr = 1'b0; req = 4'b0000; bit_in = 4'b0000; rd_lane = 2'd0;
    model_reset();
    last_gnt = 4'b0000;
    #2;
    chk("init_gnt", {4'd0, gnt}, 8'd0);
    chk("init_mv", {7'd0, match_valid}, 8'd0);
    chk("init_cnt", rd_cnt, 8'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Lane 0: 0,0,0,0,1,0
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    step(4'b0001, 4'b0001, 1'b0, 2'd0);
    step(4'b0001, 4'b0000, 1'b0, 2'd0);

    // All lanes requesting, from a cleared pointer.
    step(4'b0000, 4'b0000, 1'b1, 2'd0);
    for (int i = 0; i < 8; i++) step(4'b1111, 4'b0000, 1'b0, 2'(i));

    // Lanes 1 and 2 interleaved with zeros.
    step(4'b0000, 4'b0000, 1'b1, 2'd1);
    for (int i = 0; i < 6; i++)
      step((i % 2 == 0) ? 4'b0010 : 4'b0100, 4'b0000, 1'b0, 2'd1);

    // Lane 3 builds run=2, then clr with a 0 bit, then zeros again.
    step(4'b1000, 4'b0000, 1'b0, 2'd3);
    step(4'b1000, 4'b0000, 1'b0, 2'd3);
    step(4'b1000, 4'b0000, 1'b1, 2'd3);
    step(4'b1000, 4'b0000, 1'b0, 2'd3);
    step(4'b1000, 4'b0000, 1'b0, 2'd3);
    step(4'b1000, 4'b0000, 1'b0, 2'd3);

    // Reset between zeros on lane 0.
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    step(4'b0001, 4'b0000, 1'b0, 2'd0);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1'b0, 2'd0);

    // Randomized traffic; a requester holds its bit until granted.
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; pbit[i] = 1'b0; end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pbit[i] = ($urandom_range(0, 3) == 0);
        end
        rv[i] = pend[i];
        bv[i] = pbit[i];
      end
      step(rv, bv, ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 4; i++) if (last_gnt[i]) pend[i] = 1'b0;
    end

    // Long zero run on lane 2 saturates its counter.
    step(4'b0000, 4'b0000, 1'b1, 2'd2);
    for (int i = 0; i < 300; i++) step(4'b0100, 4'b0000, 1'b0, 2'd2);
    req = 4'b0000; rd_lane = 2'd2;
    #1;
`ifdef SEQ_MATCH_CNT_EN
    chk("cnt_sat", rd_cnt, 8'd255);
`else
    chk("cnt_off", rd_cnt, 8'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter: RUN_LEN, default 3, zero-run length that triggers detection; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clr  input  1  synchronous clear of all lane contexts and the arbiter pointer.
REQ-005 req  input  4  per-lane request; bit i high means bit_in[i] holds a valid serial bit.
REQ-006 bit_in  input  4  per-lane serial data bit.
REQ-007 gnt  output  4  one-hot grant, combinational from req, clr and the priority pointer; all zero when no request.
REQ-008 match_valid  output  1  registered one-cycle pulse marking a detection.
REQ-009 match_lane  output  2  registered lane index of the detection; meaningful only when match_valid is high.
REQ-010 rd_lane  input  2  lane select for counter readback.
REQ-011 rd_cnt  output  8  match count of lane rd_lane, combinational mux.

Function
REQ-012 One shared Mealy zero-run detector serves 4 lanes; each lane has a saved context run[i] (4 bits, saturating at RUN_LEN).
REQ-013 Arbiter: round-robin over req, starting from pointer ptr (2 bits); gnt selects the first requesting lane at or after ptr, wrapping 3->0.
REQ-014 The granted lane's bit is consumed on the clock edge where gnt is high; a requester must hold req and bit_in until granted.
REQ-015 After a grant to lane k, ptr <= k+1 mod 4; ptr is unchanged in cycles with no grant.
REQ-016 Consumed bit 1: run[k] <= 0, no match.
REQ-017 Consumed bit 0 with run[k] < RUN_LEN-1: run[k] <= run[k]+1, no match.
REQ-018 Consumed bit 0 with run[k] >= RUN_LEN-1: run[k] <= RUN_LEN; detection (overlapping), so every further 0 also detects.
REQ-019 Detection: match_valid=1 and match_lane=k in the cycle after consumption; otherwise match_valid=0 and match_lane holds its last value.
REQ-020 Contexts of non-granted lanes are unchanged; lanes never share context.
REQ-021 clr high: all run[i] <= 0, ptr <= 0, match_valid <= 0, counters <= 0 (when compiled in); gnt forced to 0 that cycle, so no bit is consumed.
REQ-022 At most one bit is consumed per cycle; 4 simultaneously requesting lanes are each served once in every 4 cycles.

Reset
REQ-023 rst asserted: run[i]=0, ptr=0, match_valid=0, match_lane=0, all counters=0, effective immediately without a clock.
REQ-024 gnt is all zero while rst is high; no bit is consumed during reset.
REQ-025 rst asserted mid-run discards partial runs; the first post-reset detection needs RUN_LEN fresh zeros.

Configuration
REQ-026 Macro SEQ_MATCH_CNT_EN defined: per-lane 8-bit match counters increment on each detection, saturate at 255, clear on rst/clr; rd_cnt returns cnt[rd_lane].
REQ-027 Macro SEQ_MATCH_CNT_EN undefined: no counters are built and rd_cnt is constant 0; all other behaviour is identical.

Verification
REQ-028 Lane 0 only, bits 0,0,0,0,1,0 -> match_valid pulses after the 3rd and 4th zeros with match_lane=0; none after the 5th and 6th bits.
REQ-029 req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... ; each lane consumed twice.
REQ-030 Interleaved lanes 1 and 2, each fed 0,0,0 alternately -> two detections (lane 1 then lane 2); no cross-lane run accumulation.
REQ-031 Lane 3 with run=2 plus clr alongside a 0 bit -> gnt=0, no match; the next 0 leaves run=1 with no match.
REQ-032 rst pulsed between two zeros on lane 0 -> outputs zero at once; 3 fresh zeros are needed for a detection.
REQ-033 SEQ_MATCH_CNT_EN defined, 300 consecutive zeros on lane 2, rd_lane=2 -> rd_cnt=255; undefined -> rd_cnt=0.
